// File: rtl/tcam_pipelined.sv
// tcam_pipelined: ternary CAM with DEPTH entries of {value, care mask, valid}.
// Searches are pipelined: one key per cycle, result two edges after the request.
// The result is the lowest-index hit, so entry 0 has the highest priority.
// Optional feature macro: TCAM_MULTI_HIT_EN adds match_count/multi_hit outputs.
//
// Strobe semantics: a request is accepted on every rising edge where
// search=1. Exactly one edge later out_valid=1 for one cycle with that
// request's result. There is no ready/backpressure: results never stall.
module tcam_pipelined #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 17,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [WIDTH-1:0]  wmask,
    input  logic              wvalid,
    input  logic              search,
    input  logic [WIDTH-1:0]  key,
`ifdef TCAM_MULTI_HIT_EN
    output logic [ADDR_W:0]   match_count,
    output logic              multi_hit,
`endif
    output logic              out_valid,
    output logic              found,
    output logic [ADDR_W-1:0] saddr,
    output logic [WIDTH-1:0]  sdata,
    output logic [WIDTH-1:0]  smask
);

    // Entry storage
    logic [WIDTH-1:0]  value_q [DEPTH];
    logic [WIDTH-1:0]  mask_q  [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    // Stage 1 registers
    logic [DEPTH-1:0]  hit_d;
    logic [DEPTH-1:0]  hit_q;
    logic              s1_valid_q;

    // Stage 2 registers
    logic              out_valid_q;
    logic              found_q;
    logic [ADDR_W-1:0] saddr_q;
    logic [WIDTH-1:0]  sdata_q;
    logic [WIDTH-1:0]  smask_q;

    // Priority encode of the stage-1 hit vector
    logic              any_hit;
    logic [ADDR_W-1:0] first_idx;
    logic              wr_in_range;

    assign wr_in_range = (32'(waddr) < DEPTH);

    // Table update: clear-all beats a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                value_q[i] <= '0;
                mask_q[i]  <= '0;
            end
            valid_q <= '0;
        end else if (clr) begin
            valid_q <= '0;
        end else if (we && wr_in_range) begin
            value_q[waddr] <= wdata;
            mask_q[waddr]  <= wmask;
            valid_q[waddr] <= wvalid;
        end
    end

    // Per-entry ternary compare against the contents held before this edge.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_d[i] = valid_q[i] && (((key ^ value_q[i]) & mask_q[i]) == '0);
        end
    end

    // Stage 1: capture the hit vector for an accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q      <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            hit_q      <= search ? hit_d : '0;
            s1_valid_q <= search;
        end
    end

    // Lowest set index wins; scanning downward leaves the smallest index last.
    always_comb begin
        any_hit   = |hit_q;
        first_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                first_idx = ADDR_W'(i);
            end
        end
    end

    // Stage 2: publish the result; entry data is read from post-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            found_q     <= 1'b0;
            saddr_q     <= '0;
            sdata_q     <= '0;
            smask_q     <= '0;
        end else if (s1_valid_q) begin
            out_valid_q <= 1'b1;
            found_q     <= any_hit;
            if (any_hit) begin
                saddr_q <= first_idx;
                sdata_q <= value_q[first_idx];
                smask_q <= mask_q[first_idx];
            end else begin
                saddr_q <= '0;
                sdata_q <= '0;
                smask_q <= '0;
            end
        end else begin
            // Idle cycle: strobe and found drop, address/data hold.
            out_valid_q <= 1'b0;
            found_q     <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign found     = found_q;
    assign saddr     = saddr_q;
    assign sdata     = sdata_q;
    assign smask     = smask_q;

`ifdef TCAM_MULTI_HIT_EN
    logic [ADDR_W:0] count_d;
    logic [ADDR_W:0] match_count_q;
    logic            multi_hit_q;

    // Popcount of the stage-1 hit vector
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + (ADDR_W + 1)'(hit_q[i]);
        end
    end

    // Stage 2 multi-hit outputs, zero whenever no result is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_count_q <= '0;
            multi_hit_q   <= 1'b0;
        end else if (s1_valid_q) begin
            match_count_q <= count_d;
            multi_hit_q   <= (count_d > (ADDR_W + 1)'(1));
        end else begin
            match_count_q <= '0;
            multi_hit_q   <= 1'b0;
        end
    end

    assign match_count = match_count_q;
    assign multi_hit   = multi_hit_q;
`endif

endmodule
